// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative, write-back, write-allocate data cache for the MEM stage.
//
// Pipeline side : cache_req, data_address, write_data, MemWrite, AddrMode in;
//                 read_data (combinational on hit), stall out.
// Flush         : flush_req pulse in; flush_busy, flush_done (one-cycle pulse) out.
// Memory side   : mem_req, WriteEnable (1=write-back, 0=refill), memory_address (line aligned),
//                 mem_writedata (victim line) out; mem_readdata, mem_ready (one-cycle pulse) in.
// Replacement   : lowest invalid way first, otherwise the oldest way of a per-set age
//                 permutation (age 0 = most recently used).
module dcache_assoc #(
    parameter int unsigned SETS       = 4,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cache_req,
    input  logic [ADDR_WIDTH-1:0]     data_address,
    input  logic [31:0]               write_data,
    input  logic                      MemWrite,
    input  logic                      AddrMode,
    output logic [31:0]               read_data,
    output logic                      stall,
    input  logic                      flush_req,
    output logic                      flush_busy,
    output logic                      flush_done,
    output logic                      mem_req,
    output logic                      WriteEnable,
    output logic [ADDR_WIDTH-1:0]     memory_address,
    output logic [32*LINE_WORDS-1:0]  mem_writedata,
    input  logic [32*LINE_WORDS-1:0]  mem_readdata,
    input  logic                      mem_ready
);

    localparam int unsigned LW       = 32 * LINE_WORDS;
    localparam int unsigned OFF_BITS = $clog2(4 * LINE_WORDS);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned TAG_W    = ADDR_WIDTH - OFF_BITS - IDX_BITS;
    localparam int unsigned IDX_W    = (SETS > 1) ? IDX_BITS : 1;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WO_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWriteback,
        StRefill,
        StFlushScan,
        StFlushWb
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   set_q, set_d;           // set of the pending miss
    logic [WAY_W-1:0]   victim_q, victim_d;     // way being replaced
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]   scan_set_q, scan_set_d;
    logic [WAY_W-1:0]   scan_way_q, scan_way_d;

    logic               valid_q [SETS][WAYS];
    logic               valid_d [SETS][WAYS];
    logic               dirty_q [SETS][WAYS];
    logic               dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]   tag_d   [SETS][WAYS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];
    logic [WAY_W-1:0]   age_d   [SETS][WAYS];
    logic [LW-1:0]      data_q  [SETS][WAYS];

    // Single line write port into the data array
    logic               line_we;
    logic [IDX_W-1:0]   line_set;
    logic [WAY_W-1:0]   line_way;
    logic [LW-1:0]      line_wdata;

    // At most one LRU touch per cycle (hit in idle or refill install)
    logic               touch_en;
    logic [IDX_W-1:0]   touch_set;
    logic [WAY_W-1:0]   touch_way;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WO_W-1:0]    req_word;
    logic [1:0]         req_byte;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim;
    logic               victim_found;
    logic [LW-1:0]      hit_line;
    logic [31:0]        hit_word;
    logic [31:0]        store_word;
    logic [LW-1:0]      store_line;
    logic               scan_last;

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                        input logic [IDX_W-1:0] s);
        logic [ADDR_WIDTH-1:0] a;
        a = (ADDR_WIDTH'(t) << (OFF_BITS + IDX_BITS)) | (ADDR_WIDTH'(s) << OFF_BITS);
        return a;
    endfunction

    // Address split, hit detection and victim choice
    always_comb begin
        req_tag  = data_address[ADDR_WIDTH-1 -: TAG_W];
        req_idx  = '0;
        req_word = '0;
        if (SETS > 1)       req_idx  = data_address[OFF_BITS +: IDX_W];
        if (LINE_WORDS > 1) req_word = data_address[2 +: WO_W];
        req_byte = data_address[1:0];

        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end

        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[req_idx][w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end

        hit_line   = data_q[req_idx][hit_way];
        hit_word   = hit_line[32*req_word +: 32];
        store_word = hit_word;
        if (AddrMode) store_word[8*req_byte +: 8] = write_data[7:0];
        else          store_word = write_data;
        store_line = hit_line;
        store_line[32*req_word +: 32] = store_word;

        scan_last = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));
    end

    // Next-state, array updates and outputs
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        victim_d   = victim_q;
        miss_tag_d = miss_tag_q;
        scan_set_d = scan_set_q;
        scan_way_d = scan_way_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        age_d      = age_q;

        line_we    = 1'b0;
        line_set   = req_idx;
        line_way   = hit_way;
        line_wdata = store_line;
        touch_en   = 1'b0;
        touch_set  = req_idx;
        touch_way  = hit_way;

        read_data      = '0;
        stall          = 1'b0;
        flush_busy     = 1'b0;
        flush_done     = 1'b0;
        mem_req        = 1'b0;
        WriteEnable    = 1'b0;
        memory_address = '0;
        mem_writedata  = '0;

        case (state_q)
            StIdle: begin
                if (cache_req && hit) begin
                    read_data = AddrMode ? {24'b0, hit_word[8*req_byte +: 8]} : hit_word;
                    touch_en  = 1'b1;
                    if (MemWrite) begin
                        line_we                   = 1'b1;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                end else if (cache_req) begin
                    stall      = 1'b1;
                    set_d      = req_idx;
                    victim_d   = victim;
                    miss_tag_d = req_tag;
                    if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StRefill;
                    end
                end
                // A pending miss blocks the flush; the pipeline retries it later
                if (flush_req && !(cache_req && !hit)) begin
                    state_d    = StFlushScan;
                    scan_set_d = '0;
                    scan_way_d = '0;
                end
            end

            StWriteback: begin
                stall          = 1'b1;
                mem_req        = 1'b1;
                WriteEnable    = 1'b1;
                memory_address = line_addr(tag_q[set_q][victim_q], set_q);
                mem_writedata  = data_q[set_q][victim_q];
                if (mem_ready) begin
                    dirty_d[set_q][victim_q] = 1'b0;
                    state_d                  = StRefill;
                end
            end

            StRefill: begin
                stall          = 1'b1;
                mem_req        = 1'b1;
                memory_address = line_addr(miss_tag_q, set_q);
                if (mem_ready) begin
                    line_we                  = 1'b1;
                    line_set                 = set_q;
                    line_way                 = victim_q;
                    line_wdata               = mem_readdata;
                    valid_d[set_q][victim_q] = 1'b1;
                    dirty_d[set_q][victim_q] = 1'b0;
                    tag_d[set_q][victim_q]   = miss_tag_q;
                    touch_en                 = 1'b1;
                    touch_set                = set_q;
                    touch_way                = victim_q;
                    state_d                  = StIdle;
                end
            end

            StFlushScan: begin
                stall      = 1'b1;
                flush_busy = 1'b1;
                if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) begin
                    state_d = StFlushWb;
                end else if (scan_last) begin
                    flush_done = 1'b1;
                    state_d    = StIdle;
                end else if (scan_way_q == WAY_W'(WAYS - 1)) begin
                    scan_way_d = '0;
                    scan_set_d = scan_set_q + 1'b1;
                end else begin
                    scan_way_d = scan_way_q + 1'b1;
                end
            end

            StFlushWb: begin
                stall          = 1'b1;
                flush_busy     = 1'b1;
                mem_req        = 1'b1;
                WriteEnable    = 1'b1;
                memory_address = line_addr(tag_q[scan_set_q][scan_way_q], scan_set_q);
                mem_writedata  = data_q[scan_set_q][scan_way_q];
                if (mem_ready) begin
                    dirty_d[scan_set_q][scan_way_q] = 1'b0;
                    if (scan_last) begin
                        flush_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StFlushScan;
                        if (scan_way_q == WAY_W'(WAYS - 1)) begin
                            scan_way_d = '0;
                            scan_set_d = scan_set_q + 1'b1;
                        end else begin
                            scan_way_d = scan_way_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        // Ways younger than the touched one age by one; the touched way becomes MRU
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                    age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
                end
            end
            age_d[touch_set][touch_way] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            set_q      <= '0;
            victim_q   <= '0;
            miss_tag_q <= '0;
            scan_set_q <= '0;
            scan_way_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    // Ages must stay a permutation, so they restart as the way number
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            victim_q   <= victim_d;
            miss_tag_q <= miss_tag_d;
            scan_set_q <= scan_set_d;
            scan_way_q <= scan_way_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            tag_q      <= tag_d;
            age_q      <= age_d;
        end
    end

    // Line storage needs no reset: valid bits guard it
    always_ff @(posedge clk) begin
        if (!rst && line_we) data_q[line_set][line_way] <= line_wdata;
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: table-driven bench for dcache_assoc (default parameters).
// A latency-3 memory responder checks each memory transaction against a queue of expected
// transactions; load results are checked against a flat architectural memory model.
`timescale 1ns/1ps
module tb_dcache_assoc;

    localparam int LW = 128;

    logic           clk = 1'b0;
    logic           rst;
    logic           cache_req;
    logic [31:0]    data_address;
    logic [31:0]    write_data;
    logic           MemWrite;
    logic           AddrMode;
    logic [31:0]    read_data;
    logic           stall;
    logic           flush_req;
    logic           flush_busy;
    logic           flush_done;
    logic           mem_req;
    logic           WriteEnable;
    logic [31:0]    memory_address;
    logic [LW-1:0]  mem_writedata;
    logic [LW-1:0]  mem_readdata;
    logic           mem_ready;

    dcache_assoc dut (
        .clk            (clk),
        .rst            (rst),
        .cache_req      (cache_req),
        .data_address   (data_address),
        .write_data     (write_data),
        .MemWrite       (MemWrite),
        .AddrMode       (AddrMode),
        .read_data      (read_data),
        .stall          (stall),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .mem_req        (mem_req),
        .WriteEnable    (WriteEnable),
        .memory_address (memory_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          bm;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_miss;
        bit          exp_wb;
        logic [31:0] wb_addr;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [LW-1:0] data;
    } mtx_t;

    vec_t          vecs1[$];
    vec_t          vecs2[$];
    mtx_t          exp_mem[$];
    logic [31:0]   exp_rd[$];
    logic [LW-1:0] backing [logic [31:0]];
    logic [31:0]   shadow  [logic [31:0]];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            mcnt     = 0;
    mtx_t          mexp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] def_line(input logic [31:0] a);
        logic [LW-1:0] l;
        if (a == 32'h10) begin
            l = {32'h44, 32'h33, 32'h22, 32'h11};
        end else begin
            for (int i = 0; i < 4; i++) l[32*i +: 32] = 32'hA500_0000 + a + 32'(4 * i);
        end
        return l;
    endfunction

    function automatic logic [LW-1:0] get_line(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : def_line(a);
    endfunction

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        logic [LW-1:0] l;
        if (shadow.exists(a)) return shadow[a];
        l = def_line(a & ~32'hF);
        return l[32*a[3:2] +: 32];
    endfunction

    function automatic logic [LW-1:0] sh_line(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = sh_word(a + 32'(4 * i));
        return l;
    endfunction

    function automatic vec_t mk(input bit we, input bit bm, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit miss, input bit wb,
                                input logic [31:0] wb_addr);
        vec_t v;
        v.we = we; v.bm = bm; v.addr = addr; v.wdata = wdata;
        v.exp_miss = miss; v.exp_wb = wb; v.wb_addr = wb_addr;
        return v;
    endfunction

    // Memory responder: answers each request with mem_ready three cycles after first seeing it
    initial begin
        mem_ready    = 1'b0;
        mem_readdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                mcnt      = 0;
            end else if (mem_req && !rst) begin
                if (mcnt == 0) begin
                    if (exp_mem.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_req: unexpected request we=%0b addr=%0h, required none",
                                 WriteEnable, memory_address);
                    end else begin
                        mexp = exp_mem.pop_front();
                        check($sformatf("mem_we@%0h", mexp.addr), WriteEnable, mexp.we);
                        check($sformatf("mem_addr@%0h", mexp.addr), memory_address, mexp.addr);
                        if (mexp.we) begin
                            check($sformatf("mem_wdata@%0h", mexp.addr), mem_writedata, mexp.data);
                        end
                    end
                    if (WriteEnable) backing[memory_address] = mem_writedata;
                    mcnt = 1;
                end else if (mcnt == 3) begin
                    if (!WriteEnable) mem_readdata = get_line(memory_address);
                    mem_ready = 1'b1;
                end else begin
                    mcnt++;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [31:0] w;
        logic [31:0] expv;
        int          cyc;
        if (v.exp_miss) begin
            if (v.exp_wb) exp_mem.push_back('{we: 1'b1, addr: v.wb_addr, data: sh_line(v.wb_addr)});
            exp_mem.push_back('{we: 1'b0, addr: (v.addr & ~32'hF), data: '0});
        end
        w = sh_word(v.addr & ~32'h3);
        if (v.we) begin
            if (v.bm) w[8*v.addr[1:0] +: 8] = v.wdata[7:0];
            else      w = v.wdata;
            shadow[v.addr & ~32'h3] = w;
        end else begin
            expv = v.bm ? ((w >> (8 * v.addr[1:0])) & 32'hFF) : w;
            exp_rd.push_back(expv);
        end

        @(negedge clk);
        cache_req    = 1'b1;
        data_address = v.addr;
        write_data   = v.wdata;
        MemWrite     = v.we;
        AddrMode     = v.bm;
        #1;
        cyc = 0;
        while (stall && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (stall) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout@%0h: stall still 1, required 0", v.addr);
        end
        check($sformatf("miss@%0h", v.addr), cyc != 0, v.exp_miss);
        if (!v.we) begin
            expv = exp_rd.pop_front();
            check($sformatf("read_data@%0h", v.addr), read_data, expv);
        end
        @(posedge clk);
        #1;
        cache_req = 1'b0;
    endtask

    task automatic run_flush(input string name);
        int dones;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        check({name, "_busy"}, flush_busy, 1'b1);
        check({name, "_stall"}, stall, 1'b1);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            if (flush_done) dones++;
            @(negedge clk);
            #1;
        end
        check({name, "_done_pulses"}, dones, 1);
        check({name, "_busy_end"}, flush_busy, 1'b0);
        check({name, "_wb_outstanding"}, exp_mem.size(), 0);
    endtask

    initial begin
        int cyc;
        rst          = 1'b1;
        cache_req    = 1'b0;
        data_address = '0;
        write_data   = '0;
        MemWrite     = 1'b0;
        AddrMode     = 1'b0;
        flush_req    = 1'b0;

        // cold fill, store/byte hit, dirty eviction, LRU order, dirty lines for the flush
        vecs1.push_back(mk(0, 0, 32'h10, 0,            1, 0, 0));
        vecs1.push_back(mk(1, 0, 32'h14, 32'hDEADBEEF, 0, 0, 0));
        vecs1.push_back(mk(0, 1, 32'h15, 0,            0, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h14, 0,            0, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h50, 0,            1, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h90, 0,            1, 1, 32'h10));
        vecs1.push_back(mk(0, 0, 32'h10, 0,            1, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h14, 0,            0, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h50, 0,            1, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h10, 0,            0, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h90, 0,            1, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h10, 0,            0, 0, 0));
        vecs1.push_back(mk(0, 0, 32'h50, 0,            1, 0, 0));
        vecs1.push_back(mk(1, 0, 32'h10, 32'h12345678, 0, 0, 0));
        vecs1.push_back(mk(1, 1, 32'h21, 32'h000000AB, 1, 0, 0));
        vecs1.push_back(mk(0, 1, 32'h21, 0,            0, 0, 0));
        // after the flush, lines are still resident
        vecs2.push_back(mk(0, 0, 32'h10, 0,            0, 0, 0));
        vecs2.push_back(mk(0, 0, 32'h20, 0,            0, 0, 0));
        vecs2.push_back(mk(0, 1, 32'h21, 0,            0, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_write_enable", WriteEnable, 1'b0);
        check("rst_memory_address", memory_address, 32'h0);
        check("rst_mem_writedata", mem_writedata, '0);
        check("rst_flush_busy", flush_busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_read_data", read_data, 32'h0);

        foreach (vecs1[i]) run_vec(vecs1[i]);

        // set 1 (0x10) is scanned before set 2 (0x20)
        exp_mem.push_back('{we: 1'b1, addr: 32'h10, data: sh_line(32'h10)});
        exp_mem.push_back('{we: 1'b1, addr: 32'h20, data: sh_line(32'h20)});
        run_flush("flush1");

        foreach (vecs2[i]) run_vec(vecs2[i]);
        run_flush("flush2");

        // reset while a refill is outstanding
        exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: '0});
        @(negedge clk);
        cache_req    = 1'b1;
        data_address = 32'h100;
        MemWrite     = 1'b0;
        AddrMode     = 1'b0;
        #1;
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("midrefill_mem_req_seen", mem_req, 1'b1);
        rst       = 1'b1;
        cache_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midrefill_mem_req_after_rst", mem_req, 1'b0);
        check("midrefill_stall_after_rst", stall, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        check("midrefill_no_late_ready_effect", stall, 1'b0);
        run_vec(mk(0, 0, 32'h10, 0, 1, 0, 0));
        run_vec(mk(0, 1, 32'h21, 0, 1, 0, 0));

        repeat (5) @(negedge clk);
        check("mem_queue_empty", exp_mem.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
